fetch_queue: RTL

- Fetch stage directly downstream of the program counter.
- Issues instruction-memory reads for the current PC, tracks in-flight requests and buffers returned instructions with their PCs in a small in-order queue for decode.
- Back-pressures the PC through a stall output. On redirect it discards all buffered and in-flight fetches.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_sync_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch stage: instruction word type,
// the canonical NOP, and the queue entry layout.
package fetch_queue_pkg;

    typedef logic [31:0] data_t;

    localparam data_t INST_NOP = 32'h0000_0013;

    typedef struct packed {
        data_t pc;
        data_t inst;
    } fetch_entry_t;

    function automatic data_t word_align(input data_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with registered storage, synchronous clear and
// asynchronous active-high reset; pop and push together are legal when full.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == '0);
    assign do_pop_s  = pop && !empty_s;
    assign do_push_s = push && (!full_s || do_pop_s);

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage; contents beyond the valid window are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues imem reads for the PC, tracks in-flight requests with
// a PC tag FIFO and buffers returned instructions in order for decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  data_t pc,
    input  logic  flush,
    output logic  fetch_stall,
    output logic  imem_req,
    output data_t imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  data_t imem_rdata,
    output logic  inst_valid,
    output data_t inst,
    output data_t inst_pc,
    input  logic  inst_ready
);

    localparam int QW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [QW-1:0] q_cnt_s;
    logic [OW-1:0] tag_cnt_s;
    logic [OW-1:0] out_cnt_r;
    logic [OW-1:0] drop_cnt_r;
    logic [OW-1:0] out_nxt_s;
    logic [OW-1:0] drop_nxt_s;
    logic          acc_s;
    logic          rsp_drop_s;
    logic          rsp_live_s;
    logic          deq_s;
    data_t         tag_pc_s;
    fetch_entry_t  enq_s;
    fetch_entry_t  head_s;

    // Credit check: queue slots cover everything in flight, and requests
    // still owed to a past redirect count against the outstanding limit.
    assign imem_req = !rst && !flush
                   && ((32'(q_cnt_s) + 32'(out_cnt_r)) < 32'(DEPTH))
                   && ((32'(out_cnt_r) + 32'(drop_cnt_r)) < 32'(MAX_OUT));
    assign imem_addr   = word_align(pc);
    assign acc_s       = imem_req && imem_gnt;
    assign fetch_stall = rst || (!flush && !acc_s);

    // A response with no live request behind it is stale and ignored.
    assign rsp_drop_s = imem_rvalid && (drop_cnt_r != '0);
    assign rsp_live_s = imem_rvalid && !flush && (drop_cnt_r == '0) && (tag_cnt_s != '0);
    assign deq_s      = !flush && inst_valid && inst_ready;

    assign enq_s.pc   = tag_pc_s;
    assign enq_s.inst = imem_rdata;

    sync_fifo #(
        .WIDTH ($bits(data_t)),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (acc_s),
        .push_data (pc),
        .pop       (rsp_live_s),
        .pop_data  (tag_pc_s),
        .count     (tag_cnt_s)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (rsp_live_s),
        .push_data (enq_s),
        .pop       (deq_s),
        .pop_data  (head_s),
        .count     (q_cnt_s)
    );

    // Next live/discard counts; on redirect every live request becomes a
    // discard except one answered in that same cycle.
    always_comb begin
        out_nxt_s  = out_cnt_r;
        drop_nxt_s = drop_cnt_r;
        if (flush) begin
            out_nxt_s = '0;
            if (imem_rvalid && ((drop_cnt_r != '0) || (out_cnt_r != '0))) begin
                drop_nxt_s = drop_cnt_r + out_cnt_r - OW'(1);
            end else begin
                drop_nxt_s = drop_cnt_r + out_cnt_r;
            end
        end else begin
            out_nxt_s  = out_cnt_r + OW'(acc_s) - OW'(rsp_live_s);
            drop_nxt_s = drop_cnt_r - OW'(rsp_drop_s);
        end
    end

    // In-flight bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_r  <= '0;
            drop_cnt_r <= '0;
        end else begin
            out_cnt_r  <= out_nxt_s;
            drop_cnt_r <= drop_nxt_s;
        end
    end

    assign inst_valid = (q_cnt_s != '0);
    assign inst       = inst_valid ? head_s.inst : INST_NOP;
    assign inst_pc    = inst_valid ? head_s.pc : 32'h0000_0000;

endmodule
